regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter NR_REGS, default 32, meaning architectural register count, which must be a power of two and at least 4.
REQ-003 The block SHALL have parameter NR_READ, default 2, meaning read port count.
REQ-004 The block SHALL have parameter NR_WRITE, default 2, meaning write port count.
REQ-005 The block SHALL derive ADDR_W as clog2(NR_REGS).
REQ-006 The block SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rstn_i  in  1  meaning reset, which is synchronous and active-low.
REQ-008 The block SHALL have port flush_i  in  1  meaning request to clear all registers and busy bits.
REQ-009 The block SHALL have port ready_o  out  1  meaning high in RUN state, low during the clear sweep.
REQ-010 The block SHALL have port raddr_i  in  NR_READ x ADDR_W  meaning read addresses.
REQ-011 The block SHALL have port rdata_o  out  NR_READ x DATA_WIDTH  meaning read data.
REQ-012 The block SHALL have port rbusy_o  out  NR_READ  meaning the addressed register has a pending write.
REQ-013 The block SHALL have port we_i  in  NR_WRITE  meaning per-port write enables.
REQ-014 The block SHALL have port waddr_i  in  NR_WRITE x ADDR_W  meaning write addresses.
REQ-015 The block SHALL have port wdata_i  in  NR_WRITE x DATA_WIDTH  meaning write data.
REQ-016 The block SHALL have port issue_valid_i  in  1  meaning request to reserve a destination register.
REQ-017 The block SHALL have port issue_rd_i  in  ADDR_W  meaning the destination register to reserve.
REQ-018 The block SHALL have port issue_ready_o  out  1  meaning the reservation is accepted this cycle.

Function
REQ-019 The block SHALL implement a state machine with states INIT and RUN: INIT moves to RUN after the sweep counter reaches NR_REGS-1; RUN moves to INIT when flush_i=1.
REQ-020 In INIT, the block SHALL clear one register and its busy bit per cycle, at counter index 0..NR_REGS-1, so the sweep takes exactly NR_REGS cycles.
REQ-021 In INIT, the block SHALL hold ready_o=0 and issue_ready_o=0, force rdata_o=0 and rbusy_o=0, and ignore all writes and issues.
REQ-022 A flush_i asserted during INIT SHALL restart the sweep counter at 0.
REQ-023 Reads SHALL be combinational: rdata_o[i] equals the register addressed by raddr_i[i].
REQ-024 Register 0 SHALL always read as 0, is never busy, and ignores writes and issues; an issue to register 0 is accepted with no effect.
REQ-025 Writes SHALL update the register array at the clock edge.
REQ-026 Write data SHALL be forwarded in the same cycle: a read of an address written this cycle returns wdata_i.
REQ-027 When several write ports target the same address, the highest-indexed port SHALL win, both for storage and for forwarding.
REQ-028 A write SHALL clear the busy bit of waddr_i at the edge.
REQ-029 rbusy_o SHALL reflect the registered busy bit, not the forwarded value.
REQ-030 issue_ready_o SHALL be 1 iff the state is RUN and the busy bit of issue_rd_i is 0, or issue_rd_i is 0; it depends on the registered busy bit only.
REQ-031 When issue_valid_i and issue_ready_o are both high, the block SHALL set busy[issue_rd_i] at the edge.
REQ-032 When an issue and a write target the same register in the same cycle, busy SHALL end set, because the issue takes priority.
REQ-033 An issue without issue_ready_o SHALL be dropped with no state change.

Reset
REQ-034 rstn_i=0 at a clock edge SHALL set state=INIT and counter=0; registers are cleared by the subsequent sweep.
REQ-035 While rstn_i=0, the block SHALL drive ready_o=0, issue_ready_o=0, rdata_o=0 and rbusy_o=0.
REQ-036 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from index 0.

Structure
REQ-037 Package regfile_pkg SHALL hold the parameter defaults and the state enum rf_state_t (INIT, RUN).
REQ-038 Busy-bit tracking SHALL live in one sub-module, rf_scoreboard, which owns the busy vector, the set/clear priority and the issue_ready_o logic.

Verification
REQ-039 Release reset, then wait: ready_o must rise exactly 32 cycles after release; every read returns 0 and busy 0.
REQ-040 Write port0 reg5=0xA5A5A5A5 with raddr0=5 in the same cycle: rdata_o[0]=0xA5A5A5A5 that cycle and after.
REQ-041 Write port0 reg7=0x1 and port1 reg7=0x2 simultaneously: reg7 reads 0x2.
REQ-042 Issue rd=9: busy9=1 and a second issue to 9 sees issue_ready_o=0; write 9 plus issue 9 in the same cycle leaves busy=1; a write alone then clears it.
REQ-043 Write reg0=0xFFFFFFFF and issue rd=0: reg0 reads 0 and is never busy.
REQ-044 Assert flush_i after writing reg3=0x3 and mid-sweep assert rstn_i=0: ready_o returns 32 cycles after release and reg3 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared parameter defaults and FSM state type for regfile_mp
package regfile_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NR_REGS    = 32;
  localparam int DEF_NR_READ    = 2;
  localparam int DEF_NR_WRITE   = 2;
  typedef enum logic {INIT, RUN} rf_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy-bit vector with sweep clear, write clear and issue set
//   i_run/i_sweep: FSM phase; i_sweep_idx: register cleared this cycle
//   i_we/i_waddr: write ports (clear busy); i_issue_*: reservation request
//   o_issue_ready: reservation accepted; o_busy: registered busy vector
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NR_REGS  = DEF_NR_REGS,
  parameter int NR_WRITE = DEF_NR_WRITE,
  parameter int ADDR_W   = $clog2(NR_REGS)
) (
  input  logic                             clk,
  input  logic                             i_run,
  input  logic                             i_sweep,
  input  logic [ADDR_W-1:0]                i_sweep_idx,
  input  logic [NR_WRITE-1:0]              i_we,
  input  logic [NR_WRITE-1:0][ADDR_W-1:0]  i_waddr,
  input  logic                             i_issue_valid,
  input  logic [ADDR_W-1:0]                i_issue_rd,
  output logic                             o_issue_ready,
  output logic [NR_REGS-1:0]               o_busy
);
  logic [NR_REGS-1:0] r_busy;
  logic [NR_REGS-1:0] w_busy_nxt;
  assign o_issue_ready = i_run && (i_issue_rd == '0 || !r_busy[i_issue_rd]);
  assign o_busy = r_busy;
  // Issue is applied after write clears so a same-cycle issue leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_sweep) w_busy_nxt[i_sweep_idx] = 1'b0;
    else if (i_run) begin
      for (int p = 0; p < NR_WRITE; p++)
        if (i_we[p]) w_busy_nxt[i_waddr[p]] = 1'b0;
      if (i_issue_valid && o_issue_ready && i_issue_rd != '0) w_busy_nxt[i_issue_rd] = 1'b1;
    end
  end
  always_ff @(posedge clk) r_busy <= w_busy_nxt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write forwarding, busy scoreboard and clear sweep
//   clk/rstn_i: clock, synchronous active-low reset; flush_i: restart clear sweep
//   ready_o: RUN state; raddr_i/rdata_o/rbusy_o: combinational read ports
//   we_i/waddr_i/wdata_i: write ports (highest index wins)
//   issue_valid_i/issue_rd_i/issue_ready_o: destination reservation
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR_REGS    = DEF_NR_REGS,
  parameter int NR_READ    = DEF_NR_READ,
  parameter int NR_WRITE   = DEF_NR_WRITE,
  localparam int ADDR_W    = $clog2(NR_REGS)
) (
  input  logic                                clk,
  input  logic                                rstn_i,
  input  logic                                flush_i,
  output logic                                ready_o,
  input  logic [NR_READ-1:0][ADDR_W-1:0]      raddr_i,
  output logic [NR_READ-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NR_READ-1:0]                  rbusy_o,
  input  logic [NR_WRITE-1:0]                 we_i,
  input  logic [NR_WRITE-1:0][ADDR_W-1:0]     waddr_i,
  input  logic [NR_WRITE-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic                                issue_valid_i,
  input  logic [ADDR_W-1:0]                   issue_rd_i,
  output logic                                issue_ready_o
);
  rf_state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [NR_REGS-1:0][DATA_WIDTH-1:0] r_regs, w_regs_nxt;
  logic [NR_REGS-1:0] w_busy;
  logic w_run, w_sweep;
  // Outputs are gated by rstn_i so they read zero while reset is held.
  assign w_run = rstn_i && r_state == RUN;
  assign w_sweep = r_state == INIT;
  assign ready_o = w_run;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    if (r_state == INIT) begin
      w_cnt_nxt = flush_i ? '0 : r_cnt + 1'b1;
      if (!flush_i && r_cnt == ADDR_W'(NR_REGS - 1)) w_state_nxt = RUN;
    end else if (flush_i) begin
      w_state_nxt = INIT;
      w_cnt_nxt = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      r_state <= INIT;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  always_comb begin
    w_regs_nxt = r_regs;
    if (w_sweep) w_regs_nxt[r_cnt] = '0;
    else if (w_run)
      for (int p = 0; p < NR_WRITE; p++)
        if (we_i[p] && waddr_i[p] != '0) w_regs_nxt[waddr_i[p]] = wdata_i[p];
  end
  always_ff @(posedge clk) r_regs <= w_regs_nxt;
  always_comb begin
    for (int i = 0; i < NR_READ; i++) begin
      rdata_o[i] = r_regs[raddr_i[i]];
      for (int p = 0; p < NR_WRITE; p++)
        if (we_i[p] && waddr_i[p] == raddr_i[i]) rdata_o[i] = wdata_i[p];
      if (!w_run || raddr_i[i] == '0) rdata_o[i] = '0;
      rbusy_o[i] = w_run && w_busy[raddr_i[i]];
    end
  end
  rf_scoreboard #(
    .NR_REGS (NR_REGS),
    .NR_WRITE(NR_WRITE),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .i_run        (w_run),
    .i_sweep      (w_sweep),
    .i_sweep_idx  (r_cnt),
    .i_we         (we_i),
    .i_waddr      (waddr_i),
    .i_issue_valid(issue_valid_i),
    .i_issue_rd   (issue_rd_i),
    .o_issue_ready(issue_ready_o),
    .o_busy       (w_busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  logic clk = 0;
  logic rstn, flush, issue_valid;
  logic [1:0][AW-1:0] raddr, waddr;
  logic [1:0][DW-1:0] rdata, wdata;
  logic [1:0] rbusy, we;
  logic [AW-1:0] issue_rd;
  logic ready, issue_ready;
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] m_regs [NR];
  bit m_busy [NR];
  int sweep_left = NR;
  always #5 clk = ~clk;
  regfile_mp dut (
    .clk          (clk),
    .rstn_i       (rstn),
    .flush_i      (flush),
    .ready_o      (ready),
    .raddr_i      (raddr),
    .rdata_o      (rdata),
    .rbusy_o      (rbusy),
    .we_i         (we),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .issue_ready_o(issue_ready)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model_clear();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 0;
    end
  endfunction
  function automatic bit model_run();
    return rstn && sweep_left == 0;
  endfunction
  function automatic void model_edge();
    bit acc;
    if (!rstn || (model_run() && flush) || (sweep_left > 0 && flush)) begin
      sweep_left = NR;
      model_clear();
    end else if (sweep_left > 0) sweep_left--;
    else begin
      acc = issue_valid && (issue_rd == 0 || !m_busy[issue_rd]);
      for (int p = 0; p < 2; p++)
        if (we[p] && waddr[p] != 0) begin
          m_regs[waddr[p]] = wdata[p];
          m_busy[waddr[p]] = 0;
        end
      if (acc && issue_rd != 0) m_busy[issue_rd] = 1;
    end
  endfunction
  task automatic check_outs(input string tag);
    logic [DW-1:0] exp;
    bit run;
    run = model_run();
    chk({tag, ".ready"}, 64'(ready), 64'(run));
    chk({tag, ".issue_ready"}, 64'(issue_ready), 64'(run && (issue_rd == 0 || !m_busy[issue_rd])));
    for (int i = 0; i < 2; i++) begin
      exp = '0;
      if (run && raddr[i] != 0) begin
        exp = m_regs[raddr[i]];
        for (int p = 0; p < 2; p++)
          if (we[p] && waddr[p] == raddr[i]) exp = wdata[p];
      end
      chk($sformatf("%s.rdata%0d", tag, i), 64'(rdata[i]), 64'(exp));
      chk($sformatf("%s.rbusy%0d", tag, i), 64'(rbusy[i]), 64'(run && m_busy[raddr[i]]));
    end
  endtask
  task automatic step(input string tag);
    #2;
    check_outs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic idle();
    flush = 0;
    we = '0;
    issue_valid = 0;
    waddr = '0;
    wdata = '0;
    issue_rd = '0;
  endtask
  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ready && k < 100) begin
      step(tag);
      k++;
    end
    chk({tag, ".latency"}, 64'(k), 64'(NR));
  endtask
  initial begin
    rstn = 0;
    raddr = '0;
    idle();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < 3; c++) step("reset");
    rstn = 1;
    wait_ready("init");
    for (int r = 0; r < NR; r += 2) begin
      raddr[0] = AW'(r);
      raddr[1] = AW'(r + 1);
      step("zero");
    end
    we[0] = 1; waddr[0] = 5; wdata[0] = 32'hA5A5A5A5; raddr[0] = 5;
    #1 chk("fwd5", 64'(rdata[0]), 64'h A5A5A5A5);
    step("wr5");
    idle();
    #1 chk("hold5", 64'(rdata[0]), 64'h A5A5A5A5);
    step("rd5");
    we = 2'b11; waddr[0] = 7; waddr[1] = 7; wdata[0] = 32'h1; wdata[1] = 32'h2; raddr[1] = 7;
    #1 chk("fwd7", 64'(rdata[1]), 64'h2);
    step("wr7");
    idle();
    #1 chk("hold7", 64'(rdata[1]), 64'h2);
    step("rd7");
    issue_valid = 1; issue_rd = 9; raddr[0] = 9;
    step("iss9");
    #1 chk("busy9", 64'(rbusy[0]), 64'h1);
    chk("iss9_again", 64'(issue_ready), 64'h0);
    step("iss9b");
    issue_valid = 0; we[0] = 1; waddr[0] = 9; wdata[0] = 32'h99;
    step("wr9");
    #1 chk("busy9_clr", 64'(rbusy[0]), 64'h0);
    issue_valid = 1; issue_rd = 9; we[0] = 1; waddr[0] = 9;
    step("wr_iss9");
    idle();
    #1 chk("busy9_prio", 64'(rbusy[0]), 64'h1);
    we[1] = 1; waddr[1] = 9; wdata[1] = 32'h42;
    step("wr9b");
    idle();
    #1 chk("busy9_final", 64'(rbusy[0]), 64'h0);
    step("rd9");
    we = 2'b11; waddr = '0; wdata[0] = '1; wdata[1] = '1; issue_valid = 1; issue_rd = 0; raddr = '0;
    #1 chk("iss0_ready", 64'(issue_ready), 64'h1);
    chk("fwd0", 64'(rdata[0]), 64'h0);
    step("wr0");
    idle();
    #1 chk("reg0", 64'(rdata[0]), 64'h0);
    chk("busy0", 64'(rbusy[0]), 64'h0);
    step("rd0");
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(63) == 0);
      issue_valid = 1'($urandom_range(1));
      issue_rd = ($urandom_range(3) == 0) ? AW'($urandom_range(3)) : AW'($urandom_range(NR - 1));
      for (int p = 0; p < 2; p++) begin
        we[p] = 1'($urandom_range(1));
        waddr[p] = ($urandom_range(2) == 0) ? AW'($urandom_range(3)) : AW'($urandom_range(NR - 1));
        wdata[p] = $urandom;
      end
      for (int i = 0; i < 2; i++)
        raddr[i] = ($urandom_range(1) == 0) ? waddr[$urandom_range(1)] : AW'($urandom_range(NR - 1));
      step("rand");
    end
    idle();
    for (int k = 0; k < 100 && !ready; k++) step("settle");
    we[0] = 1; waddr[0] = 3; wdata[0] = 32'h3;
    step("wr3");
    idle();
    flush = 1;
    step("flush");
    flush = 0;
    for (int c = 0; c < 5; c++) step("sweep");
    rstn = 0;
    step("rst_mid");
    step("rst_mid");
    rstn = 1;
    wait_ready("resweep");
    raddr[0] = 3;
    #1 chk("reg3_cleared", 64'(rdata[0]), 64'h0);
    step("rd3");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
